// File: rtl/risc19_ctrl.sv
// Multi-cycle control unit for the RISC19 datapath: fetches into IR, decodes from IR
// through EXEC/MEM/WB, keeps the flag register FR and a retired-instruction counter.
module risc19_ctrl #(
   parameter int RET_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [18:0]      instr,
   input  logic [3:0]       Flag,
   output logic             pc_en,
   output logic             PCSrc,
   output logic             RegC,
   output logic             SBSC,
   output logic             RegWE,
   output logic             CWE,
   output logic             MemWE,
   output logic             DC,
   output logic             DLDM,
   output logic             JMP,
   output logic [4:0]       ALUctrl,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_LD   = 5'b10000;
   localparam logic [4:0] OP_LDR  = 5'b10001;
   localparam logic [4:0] OP_ST   = 5'b10010;
   localparam logic [4:0] OP_JMP  = 5'b10011;
   localparam logic [4:0] OP_BEQ  = 5'b10100;
   localparam logic [4:0] OP_BNE  = 5'b10101;
   localparam logic [4:0] OP_BLT  = 5'b10110;
   localparam logic [4:0] OP_HALT = 5'b10111;

   state_t             state_q, state_d;
   logic [18:0]        ir_q, ir_d;
   logic [3:0]         fr_q, fr_d;
   logic [RET_W-1:0]   retired_q, retired_d;

   logic               pc_en_raw, regwe_raw, memwe_raw;

   // Register-field bits of IR and the C/V flags are consumed by the datapath, not here.
   logic               unused_bits;
   assign unused_bits = ^{ir_q[13:0], fr_q[3:2]};

   logic [4:0] op;
   logic       is_alu, is_ld, is_ldr, is_st, is_jmp, is_beq, is_bne, is_blt, is_halt, is_ill;
   logic       br_taken;

   assign op      = ir_q[18:14];
   assign is_alu  = (op != OP_NOP) && !op[4];
   assign is_ld   = (op == OP_LD);
   assign is_ldr  = (op == OP_LDR);
   assign is_st   = (op == OP_ST);
   assign is_jmp  = (op == OP_JMP);
   assign is_beq  = (op == OP_BEQ);
   assign is_bne  = (op == OP_BNE);
   assign is_blt  = (op == OP_BLT);
   assign is_halt = (op == OP_HALT);
   assign is_ill  = (op[4:3] == 2'b11);

   // Branches look only at the latched flags from the last ALU writeback.
   assign br_taken = (is_beq & fr_q[0]) | (is_bne & ~fr_q[0]) | (is_blt & fr_q[1]);

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      fr_d      = fr_q;
      pc_en_raw = 1'b0;
      regwe_raw = 1'b0;
      memwe_raw = 1'b0;
      PCSrc     = 1'b0;
      RegC      = 1'b0;
      SBSC      = 1'b0;
      CWE       = 1'b0;
      DC        = 1'b0;
      DLDM      = 1'b0;
      JMP       = 1'b0;
      ALUctrl   = 5'd0;
      illegal   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = instr;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_alu) begin
               ALUctrl = op;
               RegC    = 1'b1;
               state_d = S_WB;
            end else if (is_ld || is_ldr || is_st) begin
               state_d = S_MEM;
            end else if (is_halt) begin
               state_d = S_HALTED;
            end else begin
               // JMP, branches, NOP and undefined opcodes all finish here.
               pc_en_raw = 1'b1;
               PCSrc     = is_jmp | br_taken;
               JMP       = is_jmp;
               illegal   = is_ill;
               state_d   = S_FETCH;
            end
         end
         S_MEM: begin
            if (is_st) begin
               CWE       = 1'b1;
               SBSC      = 1'b1;
               memwe_raw = 1'b1;
               pc_en_raw = 1'b1;
               state_d   = S_FETCH;
            end else begin
               CWE     = is_ld;
               state_d = S_WB;
            end
         end
         S_WB: begin
            regwe_raw = 1'b1;
            DLDM      = ~is_alu;
            pc_en_raw = 1'b1;
            if (is_alu) fr_d = Flag;
            state_d   = S_FETCH;
         end
         S_HALTED: begin
            if (start) begin
               pc_en_raw = 1'b1;
               state_d   = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Reset blanks the architectural enables in the very cycle it is asserted.
   assign pc_en = pc_en_raw & rst;
   assign RegWE = regwe_raw & rst;
   assign MemWE = memwe_raw & rst;

   assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)   || (state_q == S_WB);
   assign halted  = (state_q == S_HALTED);
   assign retired = retired_q;

   always_comb begin
      retired_d = retired_q;
      if (pc_en_raw && (state_q != S_HALTED))
         retired_d = retired_q + {{(RET_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ir_q      <= 19'd0;
         fr_q      <= 4'd0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         fr_q      <= fr_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_risc19_ctrl.sv
// Scoreboard bench for risc19_ctrl: each scenario queues per-cycle stimulus with the
// expected output vector, then replays the queue and compares every cycle.
module tb_risc19_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [18:0] instr;
   logic [3:0]  Flag;
   logic        pc_en, PCSrc, RegC, SBSC, RegWE, CWE, MemWE, DC, DLDM, JMP;
   logic [4:0]  ALUctrl;
   logic        busy, halted, illegal;
   logic [15:0] retired;

   risc19_ctrl #(.RET_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .instr(instr), .Flag(Flag),
      .pc_en(pc_en), .PCSrc(PCSrc), .RegC(RegC), .SBSC(SBSC), .RegWE(RegWE),
      .CWE(CWE), .MemWE(MemWE), .DC(DC), .DLDM(DLDM), .JMP(JMP),
      .ALUctrl(ALUctrl), .busy(busy), .halted(halted), .illegal(illegal),
      .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flag-vector bit masks, MSB first: pc_en PCSrc RegC SBSC RegWE CWE MemWE DC DLDM JMP busy halted illegal
   localparam logic [12:0] PC = 13'h1000, PS = 13'h0800, RC = 13'h0400, SB = 13'h0200;
   localparam logic [12:0] RW = 13'h0100, CW = 13'h0080, MW = 13'h0040;
   localparam logic [12:0] DL = 13'h0010, JM = 13'h0008, BZ = 13'h0004, HL = 13'h0002, IL = 13'h0001;

   logic [33:0] obs;
   assign obs = {pc_en, PCSrc, RegC, SBSC, RegWE, CWE, MemWE, DC, DLDM, JMP,
                 busy, halted, illegal, ALUctrl, retired};

   typedef struct {
      string       name;
      logic        rst_v;
      logic        start_v;
      logic [18:0] instr_v;
      logic [3:0]  flag_v;
      logic [33:0] exp;
   } ent_t;

   ent_t        sb[$];
   logic [15:0] rc;
   int          n_tests;
   int          n_fail;

   function automatic logic [18:0] mk(input logic [4:0] o, input logic [3:0] rd, input logic [9:0] lo);
      return {o, rd, lo};
   endfunction

   task automatic push(input string nm, input logic r, input logic s, input logic [18:0] i,
                       input logic [3:0] f, input logic [12:0] fl, input logic [4:0] a);
      ent_t e;
      e.name = nm; e.rst_v = r; e.start_v = s; e.instr_v = i; e.flag_v = f;
      e.exp = {fl, a, rc};
      sb.push_back(e);
      if (!r) rc = 16'd0;
      else if (fl[12] && !fl[1]) rc = rc + 16'd1;
   endtask

   task automatic test_reset();
      ent_t e;
      push("rst_hold", 1'b0, 1'b1, 19'h7FFFF, 4'hF, 13'h0, 5'd0);
      push("rst_idle0", 1'b1, 1'b0, 19'h0, 4'h0, 13'h0, 5'd0);
      push("rst_idle1", 1'b1, 1'b0, 19'h12345, 4'hF, 13'h0, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_alu();
      ent_t e;
      push("alu_idle_start", 1'b1, 1'b1, 19'h0, 4'h0, 13'h0, 5'd0);
      push("alu_fetch", 1'b1, 1'b0, mk(5'b00011, 4'b0010, 10'b0001_0100_00), 4'h0, BZ, 5'd0);
      push("alu_exec", 1'b1, 1'b0, 19'h7FFFF, 4'h0, BZ | RC, 5'b00011);
      push("alu_wb", 1'b1, 1'b0, 19'h0, 4'b0001, BZ | RW | PC, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_branch();
      ent_t e;
      // FR.Z=1 from the previous ALU writeback; live Flag disagrees on purpose.
      push("beq_t_fetch", 1'b1, 1'b0, mk(5'b10100, 4'd0, 10'h00A), 4'h0, BZ, 5'd0);
      push("beq_t_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ | PC | PS, 5'd0);
      push("alu5_fetch", 1'b1, 1'b0, mk(5'b00101, 4'd1, 10'h0), 4'h0, BZ, 5'd0);
      push("alu5_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ | RC, 5'b00101);
      push("alu5_wb", 1'b1, 1'b0, 19'h0, 4'b0000, BZ | RW | PC, 5'd0);
      push("beq_nt_fetch", 1'b1, 1'b0, mk(5'b10100, 4'd0, 10'h00A), 4'h0, BZ, 5'd0);
      push("beq_nt_exec", 1'b1, 1'b0, 19'h0, 4'b0001, BZ | PC, 5'd0);
      push("bne_t_fetch", 1'b1, 1'b0, mk(5'b10101, 4'd0, 10'h015), 4'h0, BZ, 5'd0);
      push("bne_t_exec", 1'b1, 1'b0, 19'h0, 4'b0001, BZ | PC | PS, 5'd0);
      push("alu7_fetch", 1'b1, 1'b0, mk(5'b00111, 4'd3, 10'h0), 4'h0, BZ, 5'd0);
      push("alu7_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ | RC, 5'b00111);
      push("alu7_wb", 1'b1, 1'b0, 19'h0, 4'b0010, BZ | RW | PC, 5'd0);
      push("blt_t_fetch", 1'b1, 1'b0, mk(5'b10110, 4'd0, 10'h03F), 4'h0, BZ, 5'd0);
      push("blt_t_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ | PC | PS, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_jmp();
      ent_t e;
      push("jmp_fetch", 1'b1, 1'b0, mk(5'b10011, 4'd0, 10'h3FF), 4'h0, BZ, 5'd0);
      push("jmp_exec", 1'b1, 1'b1, 19'h0, 4'h0, BZ | PC | PS | JM, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_load();
      ent_t e;
      push("ld_fetch", 1'b1, 1'b0, mk(5'b10000, 4'd5, 10'h07F), 4'h0, BZ, 5'd0);
      push("ld_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ, 5'd0);
      push("ld_mem", 1'b1, 1'b0, 19'h0, 4'h0, BZ | CW, 5'd0);
      push("ld_wb", 1'b1, 1'b0, 19'h0, 4'hF, BZ | RW | DL | PC, 5'd0);
      push("ldr_fetch", 1'b1, 1'b0, mk(5'b10001, 4'd2, 10'b0011_0100_00), 4'h0, BZ, 5'd0);
      push("ldr_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ, 5'd0);
      push("ldr_mem", 1'b1, 1'b0, 19'h0, 4'h0, BZ, 5'd0);
      push("ldr_wb", 1'b1, 1'b0, 19'h0, 4'h0, BZ | RW | DL | PC, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_store();
      ent_t e;
      push("st_fetch", 1'b1, 1'b0, mk(5'b10010, 4'd3, 10'h010), 4'h0, BZ, 5'd0);
      push("st_exec", 1'b1, 1'b1, 19'h0, 4'h0, BZ, 5'd0);
      push("st_mem", 1'b1, 1'b1, 19'h0, 4'h0, BZ | CW | SB | MW | PC, 5'd0);
      push("st_next_fetch", 1'b1, 1'b0, mk(5'b00000, 4'd0, 10'h0), 4'h0, BZ, 5'd0);
      push("nop_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ | PC, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_illegal();
      ent_t e;
      push("ill_fetch", 1'b1, 1'b0, mk(5'b11010, 4'd7, 10'h155), 4'h0, BZ, 5'd0);
      push("ill_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ | IL | PC, 5'd0);
      push("ill31_fetch", 1'b1, 1'b0, mk(5'b11111, 4'd0, 10'h0), 4'h0, BZ, 5'd0);
      push("ill31_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ | IL | PC, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_back_to_back();
      ent_t        e;
      logic [4:0]  o;
      for (int k = 0; k < 8; k++) begin
         o = 5'($urandom_range(1, 15));
         push("b2b_fetch", 1'b1, 1'b0, mk(o, 4'($urandom_range(0, 15)), 10'($urandom)), 4'h0, BZ, 5'd0);
         push("b2b_exec", 1'b1, 1'b0, 19'($urandom), 4'($urandom), BZ | RC, o);
         push("b2b_wb", 1'b1, 1'b0, 19'h0, 4'($urandom), BZ | RW | PC, 5'd0);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_halt();
      ent_t e;
      push("halt_fetch", 1'b1, 1'b0, mk(5'b10111, 4'd0, 10'h0), 4'h0, BZ, 5'd0);
      push("halt_exec", 1'b1, 1'b1, 19'h0, 4'h0, BZ, 5'd0);
      for (int k = 0; k < 10; k++)
         push("halted_hold", 1'b1, 1'b0, 19'h0, 4'h0, HL, 5'd0);
      push("halted_exit", 1'b1, 1'b1, 19'h0, 4'h0, HL | PC, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   task automatic test_reset_mid();
      ent_t e;
      // Leave Z=1 in FR so the post-reset BEQ shows that FR was cleared.
      push("pre_fetch", 1'b1, 1'b0, mk(5'b00001, 4'd1, 10'h0), 4'h0, BZ, 5'd0);
      push("pre_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ | RC, 5'b00001);
      push("pre_wb", 1'b1, 1'b0, 19'h0, 4'b0001, BZ | RW | PC, 5'd0);
      push("rld_fetch", 1'b1, 1'b0, mk(5'b10000, 4'd5, 10'h07F), 4'h0, BZ, 5'd0);
      push("rld_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ, 5'd0);
      push("rld_mem_rst", 1'b0, 1'b0, 19'h0, 4'h0, BZ | CW, 5'd0);
      push("rld_idle0", 1'b1, 1'b0, 19'h0, 4'h0, 13'h0, 5'd0);
      push("rld_idle1", 1'b1, 1'b1, 19'h0, 4'h0, 13'h0, 5'd0);
      push("rst_fetch", 1'b1, 1'b0, mk(5'b10010, 4'd3, 10'h010), 4'h0, BZ, 5'd0);
      push("rst_exec", 1'b1, 1'b0, 19'h0, 4'h0, BZ, 5'd0);
      push("rst_mem_rst", 1'b0, 1'b0, 19'h0, 4'h0, BZ | CW | SB, 5'd0);
      push("rst_idle", 1'b1, 1'b1, 19'h0, 4'h0, 13'h0, 5'd0);
      push("fr0_fetch", 1'b1, 1'b0, mk(5'b10100, 4'd0, 10'h00A), 4'h0, BZ, 5'd0);
      push("fr0_beq_exec", 1'b1, 1'b0, 19'h0, 4'b0001, BZ | PC, 5'd0);
      push("fr0_after", 1'b1, 1'b0, 19'h0, 4'h0, BZ, 5'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.rst_v; start = e.start_v; instr = e.instr_v; Flag = e.flag_v;
         #1;
         n_tests++;
         if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.exp);
         end else $display("[TB] %s ok %h", e.name, obs);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rc      = 16'd0;
      rst     = 1'b0;
      start   = 1'b0;
      instr   = 19'd0;
      Flag    = 4'd0;
      repeat (2) @(posedge clk);
      test_reset();
      test_alu();
      test_branch();
      test_jmp();
      test_load();
      test_store();
      test_illegal();
      test_back_to_back();
      test_halt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
